fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Fetch stage of the pipelined MIPS core: owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents instr_F / PCPlus4_F to the fetch/decode pipeline register.
- Honours the hazard unit's fetch stall and the decode-stage branch redirect.
- Emits a NOP bubble whenever no fetched instruction is ready.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word driven on instr_F when valid_F=0 (sll $0,$0,0).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall_F  input  1  hazard-unit stall; 1 = decode register is not capturing this cycle.
- pc_src_D  input  1  branch/jump taken, resolved in decode; 1 = redirect fetch.
- pc_branch_D  input  32  redirect target, sampled when pc_src_D=1.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word address of the request (registered PC).
- imem_ack  input  1  memory completes the read in this cycle; rdata valid.
- imem_rdata  input  32  instruction word, valid only when imem_ack=1.
- instr_F  output  32  fetched instruction, or NOP_INSTR when valid_F=0.
- PCPlus4_F  output  32  address of instr_F plus 4.
- valid_F  output  1  instr_F holds a real fetched instruction.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high: reset is sampled on posedge clk and has priority over all other inputs.
- Reset values:
  - state=S_IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0.
  - valid_F=0, instr_F=NOP_INSTR, PCPlus4_F=0, kill=0, redir_pc=0.
  - Reset mid-request abandons the request; a late imem_ack after reset is ignored because the FSM is in S_IDLE.
- Memory protocol:
  - imem_req is held high with imem_addr stable until imem_ack=1 is sampled.
  - Zero-wait memory (ack in the same cycle as req) is legal.
  - imem_addr always equals pc.
- States:
  - S_IDLE: imem_req=0. Next cycle goes to S_REQ unconditionally.
  - S_REQ: imem_req=1, valid_F=0.
    - On imem_ack with kill=0 and pc_src_D=0: instr_q<=imem_rdata, PCPlus4_F<=pc+4, pc<=pc+4, valid_F<=1, go to S_FULL.
    - On no ack, remain in S_REQ.
  - S_FULL: valid_F=1, imem_req=0.
    - If stall_F=0, the instruction is consumed: valid_F<=0, go to S_REQ.
    - If stall_F=1, hold all outputs unchanged.
- Redirect (pc_src_D=1) has priority over stall_F and ack in every state except S_IDLE:
  - S_FULL: drop the buffered instruction (valid_F<=0), pc<=pc_branch_D, go to S_REQ.
  - S_REQ with imem_ack same cycle: discard imem_rdata, pc<=pc_branch_D, stay in S_REQ, kill stays 0.
  - S_REQ without ack: set kill=1, redir_pc<=pc_branch_D. pc and imem_addr stay unchanged so the handshake is not violated.
  - S_REQ, kill=1, on ack: discard rdata, pc<=redir_pc, kill<=0, stay in S_REQ.
  - A second redirect while kill=1 overwrites redir_pc; a redirect in the same cycle as the kill ack takes pc_branch_D directly.
- Arithmetic: pc+4 is modulo 2^32. From 32'hFFFF_FFFC, pc wraps to 0 and PCPlus4_F=0. The target's low 2 bits pass through unchanged.
- Each fetched instruction is presented with valid_F=1 for exactly the cycles up to and including its consuming cycle (stall_F=0). It is never duplicated.
- Baseline throughput: 1 instruction per 2 cycles with zero-wait memory.

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- Defined: in S_FULL with stall_F=0 and pc_src_D=0, imem_req=1 at imem_addr=pc in that same cycle.
  - If imem_ack is also 1, the buffer is refilled: valid_F stays 1, instr_q and PCPlus4_F update, pc<=pc+4, state stays S_FULL.
  - If imem_ack is 0, valid_F<=0 and state goes to S_REQ, where the request continues.
  - Sustains 1 instruction/cycle with zero-wait memory.
- Undefined: S_FULL never asserts imem_req; baseline behaviour above applies.

Test Plan:
- Reset then zero-wait memory returning the word address as data, stall_F=0:
  - Baseline: valid_F pulses with instr_F=0,4,8,… every 2nd cycle; PCPlus4_F=4,8,12.
  - With FETCH_PREFETCH_EN: valid_F stays 1 from the first fetch and instr_F changes every cycle.
- 3-cycle ack latency: imem_req is held 3 cycles with imem_addr=0 stable; instr_F appears the cycle after the ack.
- stall_F=1 for 4 cycles while valid_F=1, instr_F=32'h8C01_0004: outputs are frozen, imem_req=0; on release the next fetch goes to address 8.
- Redirect pc_src_D=1, pc_branch_D=32'h100 during a 3-cycle outstanding request to address 8:
  - imem_addr stays 8 until ack, that data is dropped (valid_F=0).
  - The next request is to 32'h100.
- Simultaneous pc_src_D=1 and stall_F=1 in S_FULL: the buffer is dropped, valid_F=0, and the next request is to the redirect target.
- Reset pulse during an outstanding request, followed by a late ack: state is S_IDLE, outputs are at reset values, and the first request after reset is to RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, reads instruction memory over a req/ack handshake and
// buffers one instruction for decode. Define FETCH_PREFETCH_EN to overlap refill with consume.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        pc_src_D,
  input  logic [31:0] pc_branch_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_F,
  output logic [31:0] PCPlus4_F,
  output logic        valid_F
);

  // state  | meaning
  // S_IDLE | after reset, no request outstanding
  // S_REQ  | request to imem_addr outstanding, buffer empty
  // S_FULL | buffer holds a fetched instruction awaiting decode
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pcplus4_q, pcplus4_n;
  logic [31:0] redir_pc, redir_n;
  logic        kill, kill_n;
  logic        req_c;
  logic [31:0] pc_inc;

  assign pc_inc = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0;
      redir_pc  <= 32'h0;
      kill      <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr_q   <= instr_n;
      pcplus4_q <= pcplus4_n;
      redir_pc  <= redir_n;
      kill      <= kill_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    instr_n   = instr_q;
    pcplus4_n = pcplus4_q;
    redir_n   = redir_pc;
    kill_n    = kill;
    req_c     = 1'b0;
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        req_c = 1'b1;
        if (pc_src_D) begin
          // pc may only move once the handshake completes; otherwise park the target
          if (imem_ack) begin
            pc_n   = pc_branch_D;
            kill_n = 1'b0;
          end else begin
            kill_n  = 1'b1;
            redir_n = pc_branch_D;
          end
        end else if (imem_ack) begin
          if (kill) begin
            pc_n   = redir_pc;
            kill_n = 1'b0;
          end else begin
            instr_n   = imem_rdata;
            pcplus4_n = pc_inc;
            pc_n      = pc_inc;
            state_n   = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (pc_src_D) begin
          pc_n    = pc_branch_D;
          state_n = S_REQ;
        end else if (!stall_F) begin
`ifdef FETCH_PREFETCH_EN
          req_c = 1'b1;
          if (imem_ack) begin
            instr_n   = imem_rdata;
            pcplus4_n = pc_inc;
            pc_n      = pc_inc;
          end else begin
            state_n = S_REQ;
          end
`else
          state_n = S_REQ;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign imem_req  = req_c;
  assign imem_addr = pc;
  assign valid_F   = (state == S_FULL);
  assign instr_F   = valid_F ? instr_q : NOP_INSTR;
  assign PCPlus4_F = pcplus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: throughput, latency, stall, redirect, reset and wrap.
// Expected values adapt to FETCH_PREFETCH_EN where the two builds differ.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F;
  logic        pc_src_D;
  logic [31:0] pc_branch_D;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_F;
  logic [31:0] PCPlus4_F;
  logic        valid_F;

  logic        zw;
  logic        ack_r;
  logic [31:0] rdata_r;

  int checks = 0;
  int errors = 0;

  // zero-wait memory answers every request with the word address as data
  assign imem_ack   = zw ? imem_req  : ack_r;
  assign imem_rdata = zw ? imem_addr : rdata_r;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .pc_src_D(pc_src_D),
    .pc_branch_D(pc_branch_D), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_F(instr_F),
    .PCPlus4_F(PCPlus4_F), .valid_F(valid_F)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    reset = 1'b1; zw = 1'b0; ack_r = 1'b0; rdata_r = 32'h0;
    stall_F = 1'b0; pc_src_D = 1'b0; pc_branch_D = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; zw = 1'b0; ack_r = 1'b0; rdata_r = 32'h0;
    stall_F = 1'b0; pc_src_D = 1'b0; pc_branch_D = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end checks++;
    if (valid_F !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", valid_F); end checks++;
    if (instr_F !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", instr_F); end checks++;
    if (PCPlus4_F !== 32'h0) begin errors++; $display("FAIL rst_p4: got %h exp 0", PCPlus4_F); end checks++;
  endtask

  task automatic test_zero_wait;
    logic        exp_v, exp_req;
    logic [31:0] exp_addr, exp_instr, exp_p4;
    do_reset();
    zw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
`ifdef FETCH_PREFETCH_EN
      exp_v     = (i >= 2);
      exp_req   = 1'b1;
      exp_addr  = (i >= 2) ? 32'(4 * (i - 1)) : 32'h0;
      exp_instr = (i >= 2) ? 32'(4 * (i - 2)) : 32'h0;
      exp_p4    = (i >= 2) ? 32'(4 * (i - 1)) : 32'h0;
`else
      exp_v     = (i % 2 == 0);
      exp_req   = !exp_v;
      exp_addr  = exp_v ? 32'(4 * (i / 2)) : 32'(4 * ((i - 1) / 2));
      exp_instr = exp_v ? 32'(4 * (i / 2 - 1)) : 32'h0;
      exp_p4    = exp_v ? 32'(4 * (i / 2)) : 32'(4 * ((i - 1) / 2));
`endif
      if (valid_F !== exp_v) begin errors++; $display("FAIL zw_valid[%0d]: got %b exp %b", i, valid_F, exp_v); end checks++;
      if (imem_req !== exp_req) begin errors++; $display("FAIL zw_req[%0d]: got %b exp %b", i, imem_req, exp_req); end checks++;
      if (imem_addr !== exp_addr) begin errors++; $display("FAIL zw_addr[%0d]: got %h exp %h", i, imem_addr, exp_addr); end checks++;
      if (instr_F !== exp_instr) begin errors++; $display("FAIL zw_instr[%0d]: got %h exp %h", i, instr_F, exp_instr); end checks++;
      if (PCPlus4_F !== exp_p4) begin errors++; $display("FAIL zw_p4[%0d]: got %h exp %h", i, PCPlus4_F, exp_p4); end checks++;
    end
    zw = 1'b0;
  endtask

  task automatic test_latency;
    logic exp_req;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) begin ack_r = 1'b1; rdata_r = 32'h2402_0001; end
      #1;
      if (imem_req !== 1'b1) begin errors++; $display("FAIL lat_req[%0d]: got %b exp 1", c, imem_req); end checks++;
      if (imem_addr !== 32'h0) begin errors++; $display("FAIL lat_addr[%0d]: got %h exp 0", c, imem_addr); end checks++;
      if (valid_F !== 1'b0) begin errors++; $display("FAIL lat_valid[%0d]: got %b exp 0", c, valid_F); end checks++;
    end
    @(negedge clk); ack_r = 1'b0; #1;
`ifdef FETCH_PREFETCH_EN
    exp_req = 1'b1;
`else
    exp_req = 1'b0;
`endif
    if (valid_F !== 1'b1) begin errors++; $display("FAIL lat_out_valid: got %b exp 1", valid_F); end checks++;
    if (instr_F !== 32'h2402_0001) begin errors++; $display("FAIL lat_out_instr: got %h exp 24020001", instr_F); end checks++;
    if (PCPlus4_F !== 32'h4) begin errors++; $display("FAIL lat_out_p4: got %h exp 4", PCPlus4_F); end checks++;
    if (imem_req !== exp_req) begin errors++; $display("FAIL lat_out_req: got %b exp %b", imem_req, exp_req); end checks++;
  endtask

  task automatic test_stall;
    @(negedge clk); ack_r = 1'b1; rdata_r = 32'h8C01_0004; #1;
    if (imem_addr !== 32'h4) begin errors++; $display("FAIL stl_pre_addr: got %h exp 4", imem_addr); end checks++;
    if (valid_F !== 1'b0) begin errors++; $display("FAIL stl_pre_valid: got %b exp 0", valid_F); end checks++;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); ack_r = 1'b0; stall_F = 1'b1; #1;
      if (valid_F !== 1'b1) begin errors++; $display("FAIL stl_valid[%0d]: got %b exp 1", s, valid_F); end checks++;
      if (instr_F !== 32'h8C01_0004) begin errors++; $display("FAIL stl_instr[%0d]: got %h exp 8c010004", s, instr_F); end checks++;
      if (PCPlus4_F !== 32'h8) begin errors++; $display("FAIL stl_p4[%0d]: got %h exp 8", s, PCPlus4_F); end checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL stl_req[%0d]: got %b exp 0", s, imem_req); end checks++;
    end
    @(negedge clk); stall_F = 1'b0; #1;
    if (valid_F !== 1'b1) begin errors++; $display("FAIL stl_rel_valid: got %b exp 1", valid_F); end checks++;
    @(negedge clk); #1;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL stl_next_req: got %b exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h8) begin errors++; $display("FAIL stl_next_addr: got %h exp 8", imem_addr); end checks++;
    if (valid_F !== 1'b0) begin errors++; $display("FAIL stl_next_valid: got %b exp 0", valid_F); end checks++;
  endtask

  task automatic test_redirect;
    // request to 8 is in its first cycle; redirect arrives before the ack
    pc_src_D = 1'b1; pc_branch_D = 32'h100;
    @(negedge clk); pc_src_D = 1'b0; #1;
    if (imem_addr !== 32'h8) begin errors++; $display("FAIL rd_hold_addr: got %h exp 8", imem_addr); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_hold_req: got %b exp 1", imem_req); end checks++;
    @(negedge clk); ack_r = 1'b1; rdata_r = 32'hDEAD_BEEF; #1;
    if (imem_addr !== 32'h8) begin errors++; $display("FAIL rd_ack_addr: got %h exp 8", imem_addr); end checks++;
    @(negedge clk); ack_r = 1'b0; #1;
    if (valid_F !== 1'b0) begin errors++; $display("FAIL rd_drop_valid: got %b exp 0", valid_F); end checks++;
    if (instr_F !== 32'h0) begin errors++; $display("FAIL rd_drop_instr: got %h exp 0", instr_F); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_new_req: got %b exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL rd_new_addr: got %h exp 100", imem_addr); end checks++;
    ack_r = 1'b1; rdata_r = 32'h1111_0000;
    @(negedge clk); ack_r = 1'b0; #1;
    if (valid_F !== 1'b1) begin errors++; $display("FAIL rd_tgt_valid: got %b exp 1", valid_F); end checks++;
    if (instr_F !== 32'h1111_0000) begin errors++; $display("FAIL rd_tgt_instr: got %h exp 11110000", instr_F); end checks++;
    if (PCPlus4_F !== 32'h104) begin errors++; $display("FAIL rd_tgt_p4: got %h exp 104", PCPlus4_F); end checks++;
  endtask

  task automatic test_redirect_stall;
    stall_F = 1'b1; pc_src_D = 1'b1; pc_branch_D = 32'h202; #1;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rs_req: got %b exp 0", imem_req); end checks++;
    @(negedge clk); stall_F = 1'b0; pc_src_D = 1'b0; #1;
    if (valid_F !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b exp 0", valid_F); end checks++;
    if (instr_F !== 32'h0) begin errors++; $display("FAIL rs_instr: got %h exp 0", instr_F); end checks++;
    if (imem_addr !== 32'h202) begin errors++; $display("FAIL rs_addr: got %h exp 202", imem_addr); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rs_next_req: got %b exp 1", imem_req); end checks++;
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; ack_r = 1'b1; rdata_r = 32'hBAD0_BAD0; #1;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b exp 0", imem_req); end checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h exp 0", imem_addr); end checks++;
    if (valid_F !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b exp 0", valid_F); end checks++;
    if (PCPlus4_F !== 32'h0) begin errors++; $display("FAIL rm_p4: got %h exp 0", PCPlus4_F); end checks++;
    @(negedge clk); ack_r = 1'b0; #1;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_first_req: got %b exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_first_addr: got %h exp 0", imem_addr); end checks++;
    if (valid_F !== 1'b0) begin errors++; $display("FAIL rm_late_ack: got %b exp 0", valid_F); end checks++;
  endtask

  task automatic test_wrap;
    // redirect coinciding with an ack discards the data and jumps straight away
    pc_src_D = 1'b1; pc_branch_D = 32'hFFFF_FFFC; ack_r = 1'b1; rdata_r = 32'h5555_AAAA;
    @(negedge clk); pc_src_D = 1'b0; rdata_r = 32'h0BAD_F00D; #1;
    if (valid_F !== 1'b0) begin errors++; $display("FAIL wr_drop_valid: got %b exp 0", valid_F); end checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr: got %h exp fffffffc", imem_addr); end checks++;
    @(negedge clk); ack_r = 1'b0; #1;
    if (valid_F !== 1'b1) begin errors++; $display("FAIL wr_valid: got %b exp 1", valid_F); end checks++;
    if (instr_F !== 32'h0BAD_F00D) begin errors++; $display("FAIL wr_instr: got %h exp 0badf00d", instr_F); end checks++;
    if (PCPlus4_F !== 32'h0) begin errors++; $display("FAIL wr_p4: got %h exp 0", PCPlus4_F); end checks++;
    @(negedge clk); #1;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL wr_next_addr: got %h exp 0", imem_addr); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL wr_next_req: got %b exp 1", imem_req); end checks++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
